key_input_port: RTL

- Memory-mapped input peripheral: the input-side counterpart of the memory output port that feeds the 7-segment driver.
- Samples a 16-bit raw switch bank and a raw "enter" button, debounces them, and captures the switch value on each debounced button press.
- Exposes DATA and STATUS registers to the CPU over the same addr/memory_w/data/ready bus style the memory uses.
- Runs on cpu_clk.

---
 rtl/key_input_port.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/key_input_port.sv
// Memory-mapped switch/button input port: DATA at BASE_ADDR, STATUS at BASE_ADDR+1.
// Optional irq output and STATUS mask bit are enabled by defining KEY_INPUT_IRQ_EN.
module key_input_port #(
    parameter logic [15:0] BASE_ADDR       = 16'hFF00,
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] sw,
    input  logic        btn,
    input  logic        req,
    input  logic        memory_w,
    input  logic [15:0] addr,
    input  logic [15:0] cpu_data,
    output logic [15:0] port_data,
    output logic        port_ready,
`ifdef KEY_INPUT_IRQ_EN
    output logic        irq,
`endif
    output logic        port_sel
);

    typedef enum logic [1:0] {
        IDLE,
        ACK,
        WAIT_REL
    } state_e;

    localparam logic [15:0] STAT_ADDR = BASE_ADDR + 16'd1;
    localparam logic [15:0] DEB_MAX   = 16'(DEBOUNCE_CYCLES - 1);

`ifdef KEY_INPUT_IRQ_EN
    localparam int WB = 3;
`else
    localparam int WB = 2;
`endif

    logic [15:0]   sw_s1_q, sw_s2_q;
    logic          btn_s1_q, btn_s2_q;
    logic [15:0]   sw_acc_q, sw_cand_q, sw_cnt_q;
    logic          btn_acc_q, btn_prev_q;
    logic [15:0]   btn_cnt_q;
    logic [15:0]   data_q, data_d;
    logic          valid_q, valid_d;
    logic          overrun_q, overrun_d;
    state_e        state_q;
    logic          ready_q;
    logic [15:0]   port_data_q;
    logic          is_stat_q;
    logic          wr_q;
    logic [WB-1:0] wdata_q;
    logic [15:0]   status_w;
    logic          press_w;
    logic          rd_data_w;
    logic          wr_stat_w;
    logic          unused_w;

`ifdef KEY_INPUT_IRQ_EN
    logic          mask_q, mask_d;
    logic          irq_q;
    assign irq      = irq_q;
    assign status_w = {13'b0, mask_q, overrun_q, valid_q};
    assign unused_w = ^cpu_data[15:3];
`else
    assign status_w = {14'b0, overrun_q, valid_q};
    assign unused_w = ^cpu_data[15:2];
`endif

    assign port_sel   = req && (addr == BASE_ADDR || addr == STAT_ADDR);
    assign port_data  = port_data_q;
    assign port_ready = ready_q;

    assign press_w   = btn_acc_q & ~btn_prev_q;
    assign rd_data_w = (state_q == ACK) & ~wr_q & ~is_stat_q;
    assign wr_stat_w = (state_q == ACK) & wr_q & is_stat_q;

    // Two-flop synchronizers for the asynchronous switch bank and button
    always_ff @(posedge clk) begin
        if (rst) begin
            sw_s1_q  <= '0;
            sw_s2_q  <= '0;
            btn_s1_q <= 1'b0;
            btn_s2_q <= 1'b0;
        end else begin
            sw_s1_q  <= sw;
            sw_s2_q  <= sw_s1_q;
            btn_s1_q <= btn;
            btn_s2_q <= btn_s1_q;
        end
    end

    // Switch debounce: a new candidate value restarts the count
    always_ff @(posedge clk) begin
        if (rst) begin
            sw_acc_q  <= '0;
            sw_cand_q <= '0;
            sw_cnt_q  <= '0;
        end else begin
            sw_cand_q <= sw_s2_q;
            if (sw_s2_q == sw_acc_q) begin
                sw_cnt_q <= '0;
            end else if (sw_s2_q != sw_cand_q) begin
                sw_cnt_q <= 16'd1;
            end else if (sw_cnt_q == DEB_MAX) begin
                sw_acc_q <= sw_s2_q;
                sw_cnt_q <= '0;
            end else begin
                sw_cnt_q <= sw_cnt_q + 16'd1;
            end
        end
    end

    // Button debounce plus previous-value flop for rising-edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            btn_acc_q  <= 1'b0;
            btn_prev_q <= 1'b0;
            btn_cnt_q  <= '0;
        end else begin
            btn_prev_q <= btn_acc_q;
            if (btn_s2_q == btn_acc_q) begin
                btn_cnt_q <= '0;
            end else if (btn_cnt_q == DEB_MAX) begin
                btn_acc_q <= btn_s2_q;
                btn_cnt_q <= '0;
            end else begin
                btn_cnt_q <= btn_cnt_q + 16'd1;
            end
        end
    end

    // Capture/flag next state: a press always wins over a CPU clear
    always_comb begin
        data_d    = data_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;
        if (rd_data_w || (wr_stat_w && wdata_q[0])) valid_d = 1'b0;
        if (wr_stat_w && wdata_q[1]) overrun_d = 1'b0;
        if (press_w) begin
            data_d  = sw_acc_q;
            valid_d = 1'b1;
            if (valid_q && !rd_data_w) overrun_d = 1'b1;
        end
    end

`ifdef KEY_INPUT_IRQ_EN
    // Mask next state, written from STATUS bit 2
    always_comb begin
        mask_d = mask_q;
        if (wr_stat_w) mask_d = wdata_q[2];
    end

    // Mask and registered interrupt
    always_ff @(posedge clk) begin
        if (rst) begin
            mask_q <= 1'b0;
            irq_q  <= 1'b0;
        end else begin
            mask_q <= mask_d;
            irq_q  <= valid_q & mask_q;
        end
    end
`endif

    // DATA and STATUS flag registers
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            data_q    <= data_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    // Bus handshake FSM: one ready pulse per req, read data latched on entry
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ready_q     <= 1'b0;
            port_data_q <= '0;
            is_stat_q   <= 1'b0;
            wr_q        <= 1'b0;
            wdata_q     <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (port_sel) begin
                        state_q   <= ACK;
                        ready_q   <= 1'b1;
                        is_stat_q <= (addr == STAT_ADDR);
                        wr_q      <= memory_w;
                        wdata_q   <= cpu_data[WB-1:0];
                        if (!memory_w) begin
                            port_data_q <= (addr == STAT_ADDR) ? status_w : data_q;
                        end
                    end
                end
                ACK: begin
                    ready_q <= 1'b0;
                    state_q <= WAIT_REL;
                end
                WAIT_REL: begin
                    if (!req) state_q <= IDLE;
                end
                default: begin
                    ready_q <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule
